uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between `NumReq` byte-stream requesters, such as the core's UART driver and a status/debug message source. It uses round-robin arbitration with burst locking, so a line of text from one requester is not interleaved with bytes from another. It sits between the requesters and the UART TX byte interface inside the demo system and exposes one registered valid/ready byte stream towards the transmitter.

## Interface
- `NumReq`, default 2: number of requesters; must be ≥ 2.
- `MaxBurst`, default 16: maximum bytes per grant before a forced release; must be ≥ 1.
- `clk_sys_i`  in  1: system clock.
- `rst_sys_i`  in  1: reset, synchronous and active-high.
- `req_valid_i`  in  NumReq: per-requester byte valid.
- `req_data_i`  in  NumReq*8: per-requester byte; requester k uses bits [8k+7:8k].
- `req_ready_o`  out  NumReq: per-requester accept.
- `tx_valid_o`  out  1: byte valid towards the UART TX.
- `tx_data_o`  out  8: byte towards the UART TX.
- `tx_ready_i`  in  1: UART TX accepts the byte.
- `grant_o`  out  NumReq: one-hot current grant; all zero when idle.
- `busy_o`  out  1: high when state is LOCKED or `tx_valid_o` is high.

## Operation
- **State machine:** two states, IDLE and LOCKED.
- **Registered state:**
  - `state`
  - `gnt_idx`
  - `ptr`, the round-robin start index, width $clog2(NumReq)
  - `burst_cnt`, width $clog2(MaxBurst+1)
  - the output register, `tx_valid_o` and `tx_data_o`
- **`can_load`:** equals `!tx_valid_o || tx_ready_i`.
- **IDLE:**
  - `req_ready_o` is all zero.
  - If any `req_valid_i` bit is high, select the first set index searching from `ptr` upward with wrap.
  - Load `gnt_idx`, clear `burst_cnt`, and go to LOCKED.
  - No byte transfers in the IDLE cycle.
- **LOCKED:**
  - `req_ready_o[gnt_idx] = can_load`; all other bits are 0. This signal is combinational from registers and `tx_ready_i` only.
  - **Handshake:** `req_valid_i[gnt_idx] && req_ready_o[gnt_idx]`. It loads `tx_data_o` with the byte, sets `tx_valid_o`, and increments `burst_cnt`.
  - **Release to IDLE** when any of the following holds:
    - a handshake carries byte 0x0A;
    - a handshake makes `burst_cnt` reach MaxBurst;
    - `can_load` is high and `req_valid_i[gnt_idx]` is low (the requester went idle).
  - Multiple release causes in one cycle produce a single release.
  - On release, `ptr` becomes (`gnt_idx`+1) mod NumReq.
- **Stalls:** a stall (`can_load` low) never releases the grant, even if valid drops.
- **Output register:**
  - If `tx_valid_o && tx_ready_i` with no new load, clear `tx_valid_o`.
  - `tx_data_o` holds its value when not loaded.
  - Release does not wait for the output register to drain; the next grant may begin while the last byte is still pending.
- **Non-granted requesters** see `req_ready_o` = 0 and are never dropped; their data is not sampled.

## Timing
- **Reset values:** every output is 0 (`tx_valid_o`, `tx_data_o`, `req_ready_o`, `grant_o`, `busy_o`); `state` = IDLE, `ptr` = 0, `burst_cnt` = 0.
- **Reset mid-operation:** any pending output byte is discarded; no byte is emitted after reset.
- **Latency:** with `req_valid_i` high in cycle N while IDLE:
  - `grant_o` and `req_ready_o` go high in N+1;
  - the first handshake happens in N+1;
  - `tx_valid_o` goes high in N+2.
- **Throughput:** 1 byte per cycle while `tx_ready_i` is held high.
- **Arbitration gap:** 1 idle cycle between bursts (the IDLE cycle).
- **Byte ordering:** bytes within a burst appear on `tx_data_o` in handshake order with no loss or duplication.
- **Output stability:** `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`.

## Test plan
- **Single requester, short burst:** req0 sends 0x41, 0x42, 0x0A with `tx_ready_i`=1 → TX shows 41, 42, 0A on consecutive cycles starting 2 cycles after valid; `grant_o`=01 for 3 cycles, then 00; `ptr`=1.
- **Contention with locking:** req0 and req1 both stream "AB\n" continuously from reset → TX order is A,B,0A from req0, one gap cycle, then A,B,0A from req1; there is no interleaving.
- **MaxBurst forced release:** MaxBurst=4 with req0 streaming 10 non-newline bytes and req1 valid → after 4 req0 bytes, req1 is granted; req0 resumes after req1 releases.
- **Backpressure:** `tx_ready_i` held low for 5 cycles mid-burst while req0 drops valid → `tx_data_o` is stable, `req_ready_o`=0, and the grant is held; after `tx_ready_i` rises, the grant releases once `can_load` is high.
- **Round-robin wrap:** NumReq=3 with all three requesters repeatedly sending single 0x0A bytes → grants cycle 0,1,2,0,1,2.
- **Reset mid-burst:** assert `rst_sys_i` while `tx_valid_o`=1 and `tx_ready_i`=0 → the next cycle shows all outputs at 0 and state IDLE; after reset the first grant goes to req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte stream between NumReq requesters.
// A grant stays locked until newline, MaxBurst bytes, or the owner goes idle.
module uart_tx_arbiter #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned MaxBurst = 16
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_i,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic [NumReq-1:0]     grant_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxBurst + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [IdxW-1:0] rr_sel;
  logic            rr_found;
  logic [IdxW-1:0] gnt_next;
  logic [CntW-1:0] burst_inc;
  logic [7:0]      gnt_byte;
  logic            gnt_valid;
  logic            can_load;
  logic            handshake;
  logic            release_grant;

  assign can_load  = !tx_valid_q || tx_ready_i;
  assign gnt_valid = req_valid_i[gnt_idx_q];
  assign gnt_byte  = req_data_i[{gnt_idx_q, 3'b000} +: 8];
  assign burst_inc = burst_cnt_q + 1'b1;
  assign gnt_next  = (gnt_idx_q == IdxW'(NumReq - 1)) ? '0 : gnt_idx_q + 1'b1;

  // First valid requester at or above ptr, wrapping past NumReq-1 back to 0.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] idx_w;
    rr_sel   = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = ptr_q + i;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      idx_w = IdxW'(idx);
      if (!rr_found && req_valid_i[idx_w]) begin
        rr_found = 1'b1;
        rr_sel   = idx_w;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    ptr_d         = ptr_q;
    burst_cnt_d   = burst_cnt_q;
    tx_valid_d    = tx_valid_q && !tx_ready_i;
    tx_data_d     = tx_data_q;
    req_ready_o   = '0;
    handshake     = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          gnt_idx_d   = rr_sel;
          burst_cnt_d = '0;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        req_ready_o[gnt_idx_q] = can_load;
        handshake              = gnt_valid && can_load;
        if (handshake) begin
          tx_valid_d  = 1'b1;
          tx_data_d   = gnt_byte;
          burst_cnt_d = burst_inc;
          if (gnt_byte == 8'h0A || burst_inc == CntW'(MaxBurst)) begin
            release_grant = 1'b1;
          end
        end else if (can_load) begin
          // Owner went idle while the output could take a byte; a stall never releases.
          release_grant = 1'b1;
        end
        if (release_grant) begin
          state_d = IDLE;
          ptr_d   = gnt_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o = '0;
    if (state_q == LOCKED) begin
      grant_o[gnt_idx_q] = 1'b1;
    end
  end

  assign busy_o     = (state_q == LOCKED) || tx_valid_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based reference model.
module tb_uart_tx_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic [N-1:0]     grant;
  logic             busy;

  uart_tx_arbiter #(.NumReq(N), .MaxBurst(MAXB)) dut (
    .clk_sys_i   (clk),
    .rst_sys_i   (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = nobody), start pointer, bytes in current burst,
  // and the bytes accepted from requesters but not yet taken by the transmitter.
  int         m_own;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_last;
  logic [7:0] out_q[$];

  task automatic model_reset();
    m_own  = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    m_last = 8'h00;
    out_q.delete();
  endtask

  task automatic model_step();
    bit         can;
    bit         rel;
    logic [7:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    can = (out_q.size() == 0) || tx_ready;
    rel = 0;
    if (out_q.size() != 0 && tx_ready) void'(out_q.pop_front());
    if (m_own < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_own < 0 && req_valid[(m_ptr + i) % N]) begin
          m_own = (m_ptr + i) % N;
          m_cnt = 0;
        end
      end
    end else begin
      if (req_valid[m_own] && can) begin
        b = req_data[8*m_own +: 8];
        out_q.push_back(b);
        m_last = b;
        m_cnt++;
        if (b == 8'h0A || m_cnt == MAXB) rel = 1;
      end else if (can) begin
        rel = 1;
      end
      if (rel) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    bit           can;
    e_grant = '0;
    e_ready = '0;
    can = (out_q.size() == 0) || tx_ready;
    if (m_own >= 0) begin
      e_grant[m_own] = 1'b1;
      if (can) e_ready[m_own] = 1'b1;
    end
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("tx_valid", 32'(tx_valid), 32'(out_q.size() != 0));
    check_eq("tx_data", 32'(tx_data), 32'(m_last));
    check_eq("busy", 32'(busy), 32'((m_own >= 0) || (out_q.size() != 0)));
  endtask

  int stall_left;

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    tx_ready   = 1'b0;
    stall_left = 0;
    model_reset();
    @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 99) < 85);
        req_data[8*k +: 8] = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom);
      end
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        tx_ready   = 1'b0;
        stall_left = $urandom_range(2, 6);
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      check_outputs();
      model_step();
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
